dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data-memory BRAM between the core MEM stage (port C) and the PS-side program/data loader (port L).
- Sits between mem_stage and the BRAM instance.
- Converts byte addresses to word addresses, grants one access per cycle, tracks read latency and returns read data to the owner.
- Stalls the core while its access is not granted or its read data is still in flight.

Parameters:
- ADDR_W, 10, BRAM word-address width (depth = 2**ADDR_W words)
- RD_LAT, 1, BRAM read latency in cycles; legal values 1 or 2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- core_req  in  1  core access request, held until core_stall low
- core_we  in  1  core write (1) / read (0)
- core_addr  in  32  core byte address
- core_wdata  in  32  core write data
- core_rdata  out  32  core read data, valid when core_rvalid
- core_rvalid  out  1  one-cycle pulse, core read data valid
- core_stall  out  1  freeze core pipeline
- ld_req  in  1  loader request, held until ld_gnt
- ld_we  in  1  loader write/read
- ld_addr  in  32  loader byte address
- ld_wdata  in  32  loader write data
- ld_gnt  out  1  loader request accepted this cycle
- ld_rdata  out  32  loader read data
- ld_rvalid  out  1  one-cycle pulse, loader read data valid
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM word address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data
- misalign  out  1  one-cycle pulse: granted access had addr[1:0] != 0

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - all outputs 0
  - read-tracking pipeline cleared
  - core FSM = C_IDLE
  - last_winner = L, so the core wins the first conflict
- Eligibility: core is eligible iff core_req and FSM in C_IDLE. Loader is eligible iff ld_req.
- Grant rules (combinational, at most one grant per cycle):
  - Only one eligible requester: it is granted.
  - Both eligible: grant goes to the requester that is not last_winner. last_winner updates only on conflict cycles.
- In the grant cycle:
  - mem_addr = addr[ADDR_W+1:2]; upper bits are ignored, so the address wraps.
  - mem_we = we & grant; mem_wdata = granted wdata.
  - No grant: mem_we = 0 and mem_addr holds its last value.
- Misaligned access: still executes at the truncated word address; misalign pulses in the grant cycle.
- Writes complete in the grant cycle.
  - Core write: core_stall is low in the grant cycle, high in the cycles before it.
  - Loader write: ld_gnt is high in the grant cycle.
- Reads: an {owner} token enters an RD_LAT-deep shift register at grant. When the token exits:
  - mem_rdata is routed to the owner's rdata; the owner's rvalid pulses for exactly 1 cycle.
  - The rdata outputs hold their last value otherwise.
- Core FSM:
  - C_IDLE -> C_WAIT on a granted core read.
  - C_WAIT -> C_IDLE in the cycle core_rvalid=1.
  - Core writes never leave C_IDLE.
- core_stall = (core_req & ~core_granted) | (C_IDLE & core read granted) | (C_WAIT & ~core_rvalid).
  - Stall drops in the same cycle as core_rvalid.
  - Core read total latency = RD_LAT+1 cycles from the first request cycle when uncontended.
- Loader reads are pipelined: a new loader grant is allowed while earlier loader reads are in flight. Tokens stay in order.
- While the core is in C_WAIT, the loader may be granted every cycle.
- Simultaneous core_rvalid and a new core request: the new request is eligible next cycle (FSM back in C_IDLE).
- rst mid-read: tokens dropped; no rvalid is generated for accesses issued before reset.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined: adds ports perf_conflict (out 32) and perf_stall (out 32).
  - perf_conflict counts cycles where both requesters are eligible.
  - perf_stall counts cycles with core_stall=1.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package (core_pkg): owner_e enum {OWN_CORE, OWN_LD}, core FSM state enum, DMEM_ADDR_W default constant.
- One natural sub-module, dmem_rd_tracker: RD_LAT-deep valid/owner shift register with flush on rst.

Test Plan:
- Core read 0x0000_0010 alone, BRAM word 4 = 0xDEADBEEF, RD_LAT=1 -> mem_addr=4; core_stall high 1 cycle; core_rvalid and core_rdata=0xDEADBEEF in the 2nd cycle, stall low there.
- Core write and loader write in the same cycle (core 0x8 <- 0x11, ld 0xC <- 0x22) -> core granted first, loader next cycle. Next conflict goes to the loader. Memory ends with word2=0x11, word3=0x22.
- Loader back-to-back reads of words 0,1,2 with RD_LAT=2 -> ld_gnt 3 consecutive cycles; ld_rvalid pulses 2 cycles after each grant, with data in order.
- Core read at 0x0000_0006 -> misalign pulses 1 cycle; mem_addr=1.
- rst asserted the cycle after a core read grant -> no core_rvalid ever; core_stall=0; FSM C_IDLE.
- With DMEM_ARB_PERF_EN: 5 conflict cycles -> perf_conflict=5; stall counter matches core_stall high cycles.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and defaults for the data-memory arbiter
package core_pkg;
   typedef enum logic {OWN_CORE = 1'b0, OWN_LD = 1'b1} owner_e;
   typedef enum logic {C_IDLE = 1'b0, C_WAIT = 1'b1} core_state_e;
   localparam int DMEM_ADDR_W = 10;
endpackage

// File: rtl/dmem_rd_tracker.sv
// rtl/dmem_rd_tracker.sv - RD_LAT-deep valid/owner pipe marking when BRAM read data returns
module dmem_rd_tracker
   import core_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  owner_e push_owner,
   output logic   pop,
   output owner_e pop_owner
);

   logic [RD_LAT-1:0] vld;
   owner_e            own [RD_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < RD_LAT; i++) own[i] <= OWN_CORE;
      end else begin
         vld[0] <= push;
         own[0] <= push_owner;
         for (int i = 1; i < RD_LAT; i++) begin
            vld[i] <= vld[i-1];
            own[i] <= own[i-1];
         end
      end
   end

   assign pop       = vld[RD_LAT-1];
   assign pop_owner = own[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/loader arbiter for the single-port data BRAM
// Optional counters perf_conflict/perf_stall are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
   import core_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [31:0]       core_addr,
   input  logic [31:0]       core_wdata,
   output logic [31:0]       core_rdata,
   output logic              core_rvalid,
   output logic              core_stall,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [31:0]       ld_addr,
   input  logic [31:0]       ld_wdata,
   output logic              ld_gnt,
   output logic [31:0]       ld_rdata,
   output logic              ld_rvalid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              misalign
`ifdef DMEM_ARB_PERF_EN
   ,output logic [31:0]      perf_conflict
   ,output logic [31:0]      perf_stall
`endif
);

   core_state_e       state, state_nxt;
   owner_e            last_winner, rd_owner, pop_owner;
   logic              core_elig, ld_elig, conflict, core_gnt, rd_push, pop;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, core_rdata_q, ld_rdata_q;
   logic              unused_addr_bits;

   // Upper byte-address bits are intentionally dropped: the BRAM address wraps.
   assign unused_addr_bits = ^{core_addr[31:ADDR_W+2], ld_addr[31:ADDR_W+2]};

   dmem_rd_tracker #(.RD_LAT(RD_LAT)) u_tracker (
      .clk        (clk),
      .rst        (rst),
      .push       (rd_push),
      .push_owner (rd_owner),
      .pop        (pop),
      .pop_owner  (pop_owner)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= C_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      core_elig = ~rst & core_req & (state == C_IDLE);
      ld_elig   = ~rst & ld_req;
      conflict  = core_elig & ld_elig;
      core_gnt  = core_elig & (~ld_elig | (last_winner == OWN_LD));
      ld_gnt    = ld_elig & ~core_gnt;
      rd_push   = (core_gnt & ~core_we) | (ld_gnt & ~ld_we);
      rd_owner  = core_gnt ? OWN_CORE : OWN_LD;

      mem_we    = 1'b0;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      misalign  = 1'b0;
      if (core_gnt) begin
         mem_we    = core_we;
         mem_addr  = core_addr[ADDR_W+1:2];
         mem_wdata = core_wdata;
         misalign  = |core_addr[1:0];
      end else if (ld_gnt) begin
         mem_we    = ld_we;
         mem_addr  = ld_addr[ADDR_W+1:2];
         mem_wdata = ld_wdata;
         misalign  = |ld_addr[1:0];
      end

      // Masking with rst drops a token that would surface in the reset cycle itself.
      core_rvalid = ~rst & pop & (pop_owner == OWN_CORE);
      ld_rvalid   = ~rst & pop & (pop_owner == OWN_LD);
      core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
      ld_rdata    = ld_rvalid ? mem_rdata : ld_rdata_q;

      state_nxt  = state;
      core_stall = 1'b0;
      case (state)
         C_IDLE: begin
            core_stall = core_req & ~rst & (~core_gnt | ~core_we);
            if (core_gnt & ~core_we) state_nxt = C_WAIT;
         end
         C_WAIT: begin
            core_stall = ~rst & ~core_rvalid;
            if (core_rvalid) state_nxt = C_IDLE;
         end
         default: state_nxt = C_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_winner  <= OWN_LD;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_rdata_q <= '0;
         ld_rdata_q   <= '0;
      end else begin
         if (conflict) last_winner <= core_gnt ? OWN_CORE : OWN_LD;
         if (core_gnt | ld_gnt) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
         end
         if (core_rvalid) core_rdata_q <= mem_rdata;
         if (ld_rvalid)   ld_rdata_q   <= mem_rdata;
      end
   end

`ifdef DMEM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_conflict <= '0;
         perf_stall    <= '0;
      end else begin
         if (conflict && perf_conflict != 32'hFFFF_FFFF)  perf_conflict <= perf_conflict + 32'd1;
         if (core_stall && perf_stall != 32'hFFFF_FFFF)   perf_stall    <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter at RD_LAT 1 and 2
module tb_dmem_arbiter;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   exp_t cq1[$];
   exp_t lq1[$];
   exp_t lq2[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT 1: RD_LAT = 1
   logic        core_req1 = 0, core_we1 = 0, ld_req1 = 0, ld_we1 = 0;
   logic [31:0] core_addr1 = 0, core_wdata1 = 0, ld_addr1 = 0, ld_wdata1 = 0;
   logic [31:0] core_rdata1, ld_rdata1, mem_wdata1, mem_rdata1, rd1;
   logic        core_rvalid1, core_stall1, ld_gnt1, ld_rvalid1, mem_we1, misalign1;
   logic [9:0]  mem_addr1;
   logic [31:0] mem1 [1024];
`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_conflict1, perf_stall1;
`endif

   dmem_arbiter #(.ADDR_W(10), .RD_LAT(1)) u1 (
      .clk(clk), .rst(rst),
      .core_req(core_req1), .core_we(core_we1), .core_addr(core_addr1), .core_wdata(core_wdata1),
      .core_rdata(core_rdata1), .core_rvalid(core_rvalid1), .core_stall(core_stall1),
      .ld_req(ld_req1), .ld_we(ld_we1), .ld_addr(ld_addr1), .ld_wdata(ld_wdata1),
      .ld_gnt(ld_gnt1), .ld_rdata(ld_rdata1), .ld_rvalid(ld_rvalid1),
      .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
      .misalign(misalign1)
`ifdef DMEM_ARB_PERF_EN
      , .perf_conflict(perf_conflict1), .perf_stall(perf_stall1)
`endif
   );

   always @(posedge clk) begin
      if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
      rd1 <= mem1[mem_addr1];
   end
   assign mem_rdata1 = rd1;

   // DUT 2: RD_LAT = 2, loader only
   logic        ld_req2 = 0, ld_we2 = 0;
   logic [31:0] ld_addr2 = 0, ld_wdata2 = 0;
   logic [31:0] ld_rdata2, mem_wdata2, mem_rdata2, rd2a, rd2b, unused_core_rdata2;
   logic        ld_gnt2, ld_rvalid2, mem_we2, unused_core_rvalid2, unused_core_stall2, unused_misalign2;
   logic [9:0]  mem_addr2;
   logic [31:0] mem2 [1024];
`ifdef DMEM_ARB_PERF_EN
   logic [31:0] unused_perf_conflict2, unused_perf_stall2;
`endif

   dmem_arbiter #(.ADDR_W(10), .RD_LAT(2)) u2 (
      .clk(clk), .rst(rst),
      .core_req(1'b0), .core_we(1'b0), .core_addr(32'd0), .core_wdata(32'd0),
      .core_rdata(unused_core_rdata2), .core_rvalid(unused_core_rvalid2), .core_stall(unused_core_stall2),
      .ld_req(ld_req2), .ld_we(ld_we2), .ld_addr(ld_addr2), .ld_wdata(ld_wdata2),
      .ld_gnt(ld_gnt2), .ld_rdata(ld_rdata2), .ld_rvalid(ld_rvalid2),
      .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
      .misalign(unused_misalign2)
`ifdef DMEM_ARB_PERF_EN
      , .perf_conflict(unused_perf_conflict2), .perf_stall(unused_perf_stall2)
`endif
   );

   always @(posedge clk) begin
      if (mem_we2) mem2[mem_addr2] <= mem_wdata2;
      rd2a <= mem2[mem_addr2];
      rd2b <= rd2a;
   end
   assign mem_rdata2 = rd2b;

   // Read-return monitor: every rvalid pulse must match the oldest expected entry in data and cycle.
   always @(negedge clk) begin
      exp_t e;
      if (core_rvalid1) begin
         checks++;
         if (cq1.size() == 0) begin
            errors++; $error("FAIL core1_unexpected_rvalid observed=%0h expected=0", core_rvalid1);
         end else begin
            e = cq1.pop_front();
            checks++;
            if (core_rdata1 !== e.data) begin
               errors++; $error("FAIL core1_rdata observed=%0h expected=%0h", core_rdata1, e.data);
            end
            checks++;
            if (cyc != e.cyc) begin
               errors++; $error("FAIL core1_rcycle observed=%0d expected=%0d", cyc, e.cyc);
            end
         end
      end
      if (ld_rvalid1) begin
         checks++;
         if (lq1.size() == 0) begin
            errors++; $error("FAIL ld1_unexpected_rvalid observed=%0h expected=0", ld_rvalid1);
         end else begin
            e = lq1.pop_front();
            checks++;
            if (ld_rdata1 !== e.data) begin
               errors++; $error("FAIL ld1_rdata observed=%0h expected=%0h", ld_rdata1, e.data);
            end
            checks++;
            if (cyc != e.cyc) begin
               errors++; $error("FAIL ld1_rcycle observed=%0d expected=%0d", cyc, e.cyc);
            end
         end
      end
      if (ld_rvalid2) begin
         checks++;
         if (lq2.size() == 0) begin
            errors++; $error("FAIL ld2_unexpected_rvalid observed=%0h expected=0", ld_rvalid2);
         end else begin
            e = lq2.pop_front();
            checks++;
            if (ld_rdata2 !== e.data) begin
               errors++; $error("FAIL ld2_rdata observed=%0h expected=%0h", ld_rdata2, e.data);
            end
            checks++;
            if (cyc != e.cyc) begin
               errors++; $error("FAIL ld2_rcycle observed=%0d expected=%0d", cyc, e.cyc);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic ld1_write(input logic [31:0] a, input logic [31:0] d);
      ld_req1 = 1'b1; ld_we1 = 1'b1; ld_addr1 = a; ld_wdata1 = d;
      @(negedge clk);
      checks++;
      if (ld_gnt1 !== 1'b1) begin
         errors++; $error("FAIL ld1_write_gnt observed=%0h expected=1", ld_gnt1);
      end
      next_cycle();
      ld_req1 = 1'b0; ld_we1 = 1'b0;
   endtask

   task automatic ld2_write(input logic [31:0] a, input logic [31:0] d);
      ld_req2 = 1'b1; ld_we2 = 1'b1; ld_addr2 = a; ld_wdata2 = d;
      @(negedge clk);
      checks++;
      if (ld_gnt2 !== 1'b1) begin
         errors++; $error("FAIL ld2_write_gnt observed=%0h expected=1", ld_gnt2);
      end
      next_cycle();
      ld_req2 = 1'b0; ld_we2 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=%0d expected=finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ld2_data [3];
      ld2_data[0] = 32'h0000_0100; ld2_data[1] = 32'h0000_0111; ld2_data[2] = 32'h0000_0122;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (core_stall1 !== 1'b0) begin errors++; $error("FAIL reset_core_stall observed=%0h expected=0", core_stall1); end
      checks++;
      if (core_rvalid1 !== 1'b0) begin errors++; $error("FAIL reset_core_rvalid observed=%0h expected=0", core_rvalid1); end
      checks++;
      if (ld_gnt1 !== 1'b0) begin errors++; $error("FAIL reset_ld_gnt observed=%0h expected=0", ld_gnt1); end
      checks++;
      if (mem_we1 !== 1'b0) begin errors++; $error("FAIL reset_mem_we observed=%0h expected=0", mem_we1); end
      checks++;
      if (mem_addr1 !== 10'd0) begin errors++; $error("FAIL reset_mem_addr observed=%0h expected=0", mem_addr1); end
      checks++;
      if (core_rdata1 !== 32'd0) begin errors++; $error("FAIL reset_core_rdata observed=%0h expected=0", core_rdata1); end
      checks++;
      if (misalign1 !== 1'b0) begin errors++; $error("FAIL reset_misalign observed=%0h expected=0", misalign1); end
      next_cycle();

      ld1_write(32'h0000_0010, 32'hDEAD_BEEF);
      ld1_write(32'h0000_0004, 32'hA5A5_0001);

      // Uncontended core read of word 4
      core_req1 = 1'b1; core_we1 = 1'b0; core_addr1 = 32'h0000_0010;
      @(negedge clk);
      checks++;
      if (mem_addr1 !== 10'd4) begin errors++; $error("FAIL rd_mem_addr observed=%0h expected=4", mem_addr1); end
      checks++;
      if (core_stall1 !== 1'b1) begin errors++; $error("FAIL rd_stall_grant observed=%0h expected=1", core_stall1); end
      checks++;
      if (mem_we1 !== 1'b0) begin errors++; $error("FAIL rd_mem_we observed=%0h expected=0", mem_we1); end
      cq1.push_back('{32'hDEAD_BEEF, cyc + 1});
      next_cycle();
      @(negedge clk);
      checks++;
      if (core_stall1 !== 1'b0) begin errors++; $error("FAIL rd_stall_return observed=%0h expected=0", core_stall1); end
      checks++;
      if (core_rvalid1 !== 1'b1) begin errors++; $error("FAIL rd_rvalid observed=%0h expected=1", core_rvalid1); end
      next_cycle();
      core_req1 = 1'b0;

      // Write conflict: core wins first, loader next cycle
      core_req1 = 1'b1; core_we1 = 1'b1; core_addr1 = 32'h8; core_wdata1 = 32'h11;
      ld_req1 = 1'b1; ld_we1 = 1'b1; ld_addr1 = 32'hC; ld_wdata1 = 32'h22;
      @(negedge clk);
      checks++;
      if (mem_we1 !== 1'b1) begin errors++; $error("FAIL wc_core_mem_we observed=%0h expected=1", mem_we1); end
      checks++;
      if (mem_addr1 !== 10'd2) begin errors++; $error("FAIL wc_core_mem_addr observed=%0h expected=2", mem_addr1); end
      checks++;
      if (mem_wdata1 !== 32'h11) begin errors++; $error("FAIL wc_core_wdata observed=%0h expected=11", mem_wdata1); end
      checks++;
      if (core_stall1 !== 1'b0) begin errors++; $error("FAIL wc_core_stall observed=%0h expected=0", core_stall1); end
      checks++;
      if (ld_gnt1 !== 1'b0) begin errors++; $error("FAIL wc_ld_not_gnt observed=%0h expected=0", ld_gnt1); end
      next_cycle();
      core_req1 = 1'b0; core_we1 = 1'b0;
      @(negedge clk);
      checks++;
      if (ld_gnt1 !== 1'b1) begin errors++; $error("FAIL wc_ld_gnt observed=%0h expected=1", ld_gnt1); end
      checks++;
      if (mem_addr1 !== 10'd3) begin errors++; $error("FAIL wc_ld_mem_addr observed=%0h expected=3", mem_addr1); end
      checks++;
      if (mem_wdata1 !== 32'h22) begin errors++; $error("FAIL wc_ld_wdata observed=%0h expected=22", mem_wdata1); end
      next_cycle();
      ld_req1 = 1'b0; ld_we1 = 1'b0;
      @(negedge clk);
      checks++;
      if (mem1[2] !== 32'h11) begin errors++; $error("FAIL mem_word2 observed=%0h expected=11", mem1[2]); end
      checks++;
      if (mem1[3] !== 32'h22) begin errors++; $error("FAIL mem_word3 observed=%0h expected=22", mem1[3]); end
      next_cycle();

      // Read conflict: loader wins this time
      core_req1 = 1'b1; core_we1 = 1'b0; core_addr1 = 32'h8;
      ld_req1 = 1'b1; ld_we1 = 1'b0; ld_addr1 = 32'hC;
      @(negedge clk);
      checks++;
      if (ld_gnt1 !== 1'b1) begin errors++; $error("FAIL rc_ld_gnt observed=%0h expected=1", ld_gnt1); end
      checks++;
      if (core_stall1 !== 1'b1) begin errors++; $error("FAIL rc_core_stall observed=%0h expected=1", core_stall1); end
      checks++;
      if (mem_addr1 !== 10'd3) begin errors++; $error("FAIL rc_mem_addr_ld observed=%0h expected=3", mem_addr1); end
      lq1.push_back('{32'h22, cyc + 1});
      next_cycle();
      ld_req1 = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_addr1 !== 10'd2) begin errors++; $error("FAIL rc_mem_addr_core observed=%0h expected=2", mem_addr1); end
      checks++;
      if (core_stall1 !== 1'b1) begin errors++; $error("FAIL rc_core_stall_grant observed=%0h expected=1", core_stall1); end
      cq1.push_back('{32'h11, cyc + 1});
      next_cycle();
      @(negedge clk);
      checks++;
      if (core_stall1 !== 1'b0) begin errors++; $error("FAIL rc_core_stall_done observed=%0h expected=0", core_stall1); end
      next_cycle();
      core_req1 = 1'b0;

      // Misaligned core read at 0x6
      core_req1 = 1'b1; core_addr1 = 32'h6;
      @(negedge clk);
      checks++;
      if (misalign1 !== 1'b1) begin errors++; $error("FAIL mis_pulse observed=%0h expected=1", misalign1); end
      checks++;
      if (mem_addr1 !== 10'd1) begin errors++; $error("FAIL mis_mem_addr observed=%0h expected=1", mem_addr1); end
      cq1.push_back('{32'hA5A5_0001, cyc + 1});
      next_cycle();
      @(negedge clk);
      checks++;
      if (misalign1 !== 1'b0) begin errors++; $error("FAIL mis_pulse_end observed=%0h expected=0", misalign1); end
      next_cycle();
      core_req1 = 1'b0;

      // Reset in the cycle after a core read grant: the read must never return
      core_req1 = 1'b1; core_addr1 = 32'h10;
      @(negedge clk);
      checks++;
      if (core_stall1 !== 1'b1) begin errors++; $error("FAIL rst_rd_granted_stall observed=%0h expected=1", core_stall1); end
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (core_rvalid1 !== 1'b0) begin errors++; $error("FAIL rst_no_rvalid observed=%0h expected=0", core_rvalid1); end
      next_cycle();
      rst = 1'b0; core_req1 = 1'b0;
      @(negedge clk);
      checks++;
      if (core_stall1 !== 1'b0) begin errors++; $error("FAIL rst_stall_low observed=%0h expected=0", core_stall1); end
      repeat (3) next_cycle();
      core_req1 = 1'b1; core_we1 = 1'b1; core_addr1 = 32'h0; core_wdata1 = 32'h55;
      @(negedge clk);
      checks++;
      if (core_stall1 !== 1'b0) begin errors++; $error("FAIL rst_fsm_idle_stall observed=%0h expected=0", core_stall1); end
      checks++;
      if (mem_we1 !== 1'b1) begin errors++; $error("FAIL rst_fsm_idle_we observed=%0h expected=1", mem_we1); end
      next_cycle();
      core_req1 = 1'b0; core_we1 = 1'b0;

      // RD_LAT=2 pipelined loader reads
      for (int i = 0; i < 3; i++) ld2_write(32'(i * 4), ld2_data[i]);
      for (int i = 0; i < 3; i++) begin
         ld_req2 = 1'b1; ld_we2 = 1'b0; ld_addr2 = 32'(i * 4);
         @(negedge clk);
         checks++;
         if (ld_gnt2 !== 1'b1) begin errors++; $error("FAIL ld2_rd_gnt observed=%0h expected=1", ld_gnt2); end
         checks++;
         if (mem_addr2 !== 10'(i)) begin errors++; $error("FAIL ld2_rd_addr observed=%0h expected=%0h", mem_addr2, i); end
         lq2.push_back('{ld2_data[i], cyc + 2});
         next_cycle();
      end
      ld_req2 = 1'b0;

`ifdef DMEM_ARB_PERF_EN
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      core_req1 = 1'b1; core_we1 = 1'b1; core_addr1 = 32'h40; core_wdata1 = 32'h1;
      ld_req1 = 1'b1; ld_we1 = 1'b1; ld_addr1 = 32'h44; ld_wdata1 = 32'h2;
      repeat (5) next_cycle();
      core_req1 = 1'b0; core_we1 = 1'b0; ld_req1 = 1'b0; ld_we1 = 1'b0;
      @(negedge clk);
      checks++;
      if (perf_conflict1 !== 32'd5) begin errors++; $error("FAIL perf_conflict observed=%0h expected=5", perf_conflict1); end
      checks++;
      if (perf_stall1 !== 32'd2) begin errors++; $error("FAIL perf_stall observed=%0h expected=2", perf_stall1); end
      next_cycle();
`endif

      for (int i = 0; i < 20 && (cq1.size() + lq1.size() + lq2.size()) != 0; i++) next_cycle();
      checks++;
      if (cq1.size() != 0) begin errors++; $error("FAIL drain_core1 observed=%0d expected=0", cq1.size()); end
      checks++;
      if (lq1.size() != 0) begin errors++; $error("FAIL drain_ld1 observed=%0d expected=0", lq1.size()); end
      checks++;
      if (lq2.size() != 0) begin errors++; $error("FAIL drain_ld2 observed=%0d expected=0", lq2.size()); end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
